// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch and a data requester.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAIT_CYC   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  if (WAIT_CYC < 1 || WAIT_CYC > 15 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_arbiter: WAIT_CYC must be 1..15 and STARVE_MAX at least 1");
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic xfer_done;
  logic cand_f, cand_d, force_f;
  logic grant_f, grant_d;

  assign xfer_done = (state_q != IDLE) && (cnt_q == 4'd0);
  assign if_ack    = xfer_done && (state_q == IF_ACC);
  assign d_ack     = xfer_done && (state_q == D_ACC);

  // The requester being acked still holds its req this cycle, so it is masked out.
  assign cand_f = if_req && !if_ack;
  assign cand_d = d_req && !d_ack;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  assign force_f = cand_f && (starve_q >= STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_f) begin
      starve_d = '0;
    end else if (grant_d && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_f = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_f    = 1'b0;
    grant_d    = 1'b0;

    if (state_q == IDLE || xfer_done) begin
      if (force_f) begin
        grant_f = 1'b1;
      end else if (cand_d) begin
        grant_d = 1'b1;
      end else if (cand_f) begin
        grant_f = 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
    end

    if (if_ack) begin
      if_rdata_d = mem_rdata;
    end
    if (d_ack && !we_q) begin
      d_rdata_d = mem_rdata;
    end

    if (grant_d) begin
      state_d = D_ACC;
      cnt_d   = CNT_LOAD;
      addr_d  = d_addr;
      we_d    = d_we;
      wdata_d = d_wdata;
    end else if (grant_f) begin
      state_d = IF_ACC;
      cnt_d   = CNT_LOAD;
      addr_d  = if_addr;
      we_d    = 1'b0;
    end else if (state_q == IDLE || xfer_done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Address and write data are the latched grant values, so they hold through IDLE.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == IF_ACC) || ((state_q == D_ACC) && !we_q);
  assign mem_we    = (state_q == D_ACC) && we_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req && !if_ack) || (d_req && !d_ack);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a transaction model.
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  logic          use_dir = 1'b1;
  logic [DW-1:0] dir_rdata = '0;
  logic [31:0]   salt = '0;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign mem_rdata = use_dir ? dir_rdata : (mem_hash(mem_addr) ^ salt);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: owner and remaining cycles of the current transfer.
  int          m_own;
  int          m_rem;
  logic [31:0] m_addr, m_wdata, e_ifr, e_dr;
  logic        m_we;
  int          m_starve;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    rst_n = 1'b1;

    // ---------------- single fetch ----------------
    @(negedge clk);
    dir_rdata = 32'h2001000A;
    if_req = 1'b1; if_addr = 32'h40;
    #1 check("f_stall_req", stall, 1);
    @(negedge clk);
    check("f_re1", mem_re, 1);
    check("f_addr", mem_addr, 32'h40);
    check("f_ack_early", if_ack, 0);
    @(negedge clk);
    check("f_re2", mem_re, 1);
    check("f_ack", if_ack, 1);
    check("f_stall_ack", stall, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("f_re_idle", mem_re, 0);
    check("f_ack_pulse", if_ack, 0);
    check("f_rdata", if_rdata, 32'h2001000A);
    check("f_stall_after", stall, 0);

    // ---------------- simultaneous data write + fetch ----------------
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    dir_rdata = 32'hCAFE0001;
    @(negedge clk);
    check("c_we1", mem_we, 1);
    check("c_re1", mem_re, 0);
    check("c_addr", mem_addr, 32'h100);
    check("c_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("c_we2", mem_we, 1);
    check("c_dack", {d_ack, if_ack}, 2'b10);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("c_if_direct", {mem_re, mem_we}, 2'b10);
    check("c_if_addr", mem_addr, 32'h200);
    check("c_acks_mid", {d_ack, if_ack}, 2'b00);
    @(negedge clk);
    check("c_ifack", {d_ack, if_ack}, 2'b01);
    if_req = 1'b0;
    @(negedge clk);
    check("c_if_rdata", if_rdata, 32'hCAFE0001);
    check("c_d_rdata_kept", d_rdata, 0);

    // ---------------- reset mid data access ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    dir_rdata = 32'h12345678;
    @(negedge clk);
    check("r_re_before", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_outs", {mem_re, mem_we, d_ack, if_ack}, 0);
    check("r_addr", mem_addr, 0);
    check("r_wdata", mem_wdata, 0);
    check("r_if_rdata", if_rdata, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("r_idle", {mem_re, d_ack}, 2'b00);
    check("r_stall", stall, 1);
    @(negedge clk);
    check("r_regrant", mem_re, 1);
    check("r_no_ack", d_ack, 0);
    @(negedge clk);
    check("r_dack", d_ack, 1);
    d_req = 1'b0;
    @(negedge clk);
    check("r_d_rdata", d_rdata, 32'h12345678);

    // ---------------- randomized traffic vs model ----------------
    rst_n = 1'b0;
    use_dir = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_own = 0; m_rem = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
    e_ifr = '0; e_dr = '0; m_starve = 0;

    for (int ph = 0; ph < 2; ph++) begin
      for (int cyc = 0; cyc < 1500; cyc++) begin
        logic e_ifack, e_dack, cd, cf, gf, gd, frc;
        @(negedge clk);
        e_ifack = (m_own == 1) && (m_rem == 1);
        e_dack  = (m_own == 2) && (m_rem == 1);
        check("m_acks", {if_ack, d_ack}, {e_ifack, e_dack});
        check("m_re", mem_re, (m_own == 1) || (m_own == 2 && !m_we));
        check("m_we", mem_we, (m_own == 2) && m_we);
        check("m_addr", mem_addr, m_addr);
        if (m_own == 2 && m_we) check("m_wdata", mem_wdata, m_wdata);
        check("m_stall", stall, (if_req && !e_ifack) || (d_req && !e_dack));
        check("m_if_rdata", if_rdata, e_ifr);
        check("m_d_rdata", d_rdata, e_dr);

        if (e_ifack) e_ifr = mem_hash(m_addr) ^ salt;
        if (e_dack && !m_we) e_dr = mem_hash(m_addr) ^ salt;
        gf = 1'b0; gd = 1'b0;
        if (m_own != 0 && m_rem > 1) begin
          m_rem--;
        end else begin
          cd = d_req && !e_dack;
          cf = if_req && !e_ifack;
`ifdef MEM_ARB_STARVE_GUARD_EN
          frc = cf && (m_starve >= SM);
`else
          frc = 1'b0;
`endif
          if (frc) gf = 1'b1;
          else if (cd) gd = 1'b1;
          else if (cf) gf = 1'b1;
          if (gd) begin
            m_own = 2; m_rem = W; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          end else if (gf) begin
            m_own = 1; m_rem = W; m_addr = if_addr; m_we = 1'b0;
          end else begin
            m_own = 0;
          end
        end
        if (!if_req || gf) m_starve = 0;
        else if (gd && m_starve < SM) m_starve++;

        @(posedge clk);
        #1;
        salt = $urandom;
        // Requesters: hold until ack, then drop or immediately reissue.
        if (!if_req || e_ifack) begin
          if_req  = (ph == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
          if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req || e_dack) begin
          d_req   = (ph == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
          d_we    = $urandom_range(0, 1);
          d_addr  = $urandom & 32'hFFFF_FFFC;
          d_wdata = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
